// File: rtl/dac_spi_rx.sv
// Serial receiver that emulates the input/DAC register pair of an SPI DAC.
// Define DAC_SPI_RX_SYNC_EN to get a two-flop input synchronizer for asynchronous SPI pins.
module dac_spi_rx #(
    parameter int DAC_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sclk,
    input  logic                 i_mosi,
    input  logic                 i_cs_n,
    input  logic                 i_ldac_n,
    output logic [DAC_WIDTH-1:0] o_input_reg,
    output logic [DAC_WIDTH-1:0] o_dac_code,
    output logic                 o_word_valid,
    output logic                 o_update,
    output logic                 o_err_short,
    output logic                 o_err_long,
    output logic [CNT_WIDTH-1:0] o_frame_count
);

`ifdef DAC_SPI_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int BW = $clog2(DAC_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DAC_WIDTH - 1);
    // Packed as {cs_n, ldac_n, sclk, mosi}; reset to the idle levels of the bus.
    localparam logic [3:0] IN_IDLE = 4'b1100;

    typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_RECV, ST_FULL} state_t;

    logic [3:0]           raw;
    logic [3:0]           stage_q;
    logic [3:1]           prev_q;
    logic                 csRise_q, csFall_q, sclkRise_q, ldacFall_q, csHigh_q, mosi_q;
    logic [LAT:0]         fill_q;
    logic                 sclkShift;
    state_t               state_q, state_d;
    logic [BW-1:0]        bitCnt_q, bitCnt_d;
    logic [DAC_WIDTH-1:0] shift_q, shift_d;
    logic                 long_q, long_d;
    logic [DAC_WIDTH-1:0] inputReg_q, inputReg_d, dac_q, dac_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 wordValid_q, wordValid_d, update_q, update_d;
    logic                 errShort_q, errShort_d, errLong_q, errLong_d;

    assign raw = {i_cs_n, i_ldac_n, i_sclk, i_mosi};

`ifdef DAC_SPI_RX_SYNC_EN
    logic [3:0] meta_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q  <= IN_IDLE;
            stage_q <= IN_IDLE;
        end else begin
            meta_q  <= raw;
            stage_q <= meta_q;
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) stage_q <= IN_IDLE;
        else          stage_q <= raw;
    end
`endif

    // Edge flags are registered so mosi_q and csHigh_q stay aligned with them;
    // fill_q marks when csHigh_q first reflects a real sample rather than reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q     <= IN_IDLE[3:1];
            csRise_q   <= 1'b0;
            csFall_q   <= 1'b0;
            sclkRise_q <= 1'b0;
            ldacFall_q <= 1'b0;
            csHigh_q   <= 1'b1;
            mosi_q     <= 1'b0;
            fill_q     <= '0;
        end else begin
            prev_q     <= stage_q[3:1];
            csRise_q   <= stage_q[3] & ~prev_q[3];
            csFall_q   <= ~stage_q[3] & prev_q[3];
            ldacFall_q <= ~stage_q[2] & prev_q[2];
            sclkRise_q <= stage_q[1] & ~prev_q[1];
            csHigh_q   <= stage_q[3];
            mosi_q     <= stage_q[0];
            fill_q     <= {fill_q[LAT-1:0], 1'b1};
        end
    end

    assign sclkShift = sclkRise_q & ~csHigh_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_WAIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (fill_q[LAT] && csHigh_q) state_d = ST_IDLE;
            ST_IDLE: if (csFall_q) state_d = ST_RECV;
            ST_RECV: begin
                if (csRise_q)                                state_d = ST_IDLE;
                else if (sclkShift && bitCnt_q == LAST_BIT)  state_d = ST_FULL;
            end
            ST_FULL: if (csRise_q) state_d = ST_IDLE;
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        long_d      = long_q;
        inputReg_d  = inputReg_q;
        dac_d       = dac_q;
        count_d     = count_q;
        wordValid_d = 1'b0;
        update_d    = 1'b0;
        errShort_d  = 1'b0;
        errLong_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csFall_q) begin
                    bitCnt_d = '0;
                    shift_d  = '0;
                    long_d   = 1'b0;
                end
            end
            ST_RECV: begin
                if (csRise_q) begin
                    errShort_d = 1'b1;
                end else if (sclkShift) begin
                    shift_d  = (shift_q << 1) | DAC_WIDTH'(mosi_q);
                    bitCnt_d = bitCnt_q + BW'(1);
                end
            end
            ST_FULL: begin
                if (csRise_q) begin
                    if (long_q) begin
                        errLong_d = 1'b1;
                    end else begin
                        inputReg_d  = shift_q;
                        wordValid_d = 1'b1;
                        count_d     = count_q + CNT_WIDTH'(1);
                    end
                end else if (sclkShift) begin
                    long_d = 1'b1;
                end
            end
            default: ;
        endcase
        // Taking inputReg_d lets a coincident LDAC pick up the word just received.
        if (state_q != ST_WAIT && ldacFall_q) begin
            dac_d    = inputReg_d;
            update_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bitCnt_q    <= '0;
            shift_q     <= '0;
            long_q      <= 1'b0;
            inputReg_q  <= '0;
            dac_q       <= '0;
            count_q     <= '0;
            wordValid_q <= 1'b0;
            update_q    <= 1'b0;
            errShort_q  <= 1'b0;
            errLong_q   <= 1'b0;
        end else begin
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            long_q      <= long_d;
            inputReg_q  <= inputReg_d;
            dac_q       <= dac_d;
            count_q     <= count_d;
            wordValid_q <= wordValid_d;
            update_q    <= update_d;
            errShort_q  <= errShort_d;
            errLong_q   <= errLong_d;
        end
    end

    assign o_input_reg   = inputReg_q;
    assign o_dac_code    = dac_q;
    assign o_word_valid  = wordValid_q;
    assign o_update      = update_q;
    assign o_err_short   = errShort_q;
    assign o_err_long    = errLong_q;
    assign o_frame_count = count_q;

endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: a frame-level model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_dac_spi_rx;

    localparam int W  = 16;
    localparam int CW = 16;
`ifdef DAC_SPI_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int K_WORD  = 0;
    localparam int K_SHORT = 1;
    localparam int K_LONG  = 2;
    localparam int K_UPD   = 3;

    logic          i_clk    = 1'b0;
    logic          i_rst_n  = 1'b0;
    logic          i_sclk   = 1'b0;
    logic          i_mosi   = 1'b0;
    logic          i_cs_n   = 1'b1;
    logic          i_ldac_n = 1'b1;
    logic [W-1:0]  o_input_reg;
    logic [W-1:0]  o_dac_code;
    logic          o_word_valid;
    logic          o_update;
    logic          o_err_short;
    logic          o_err_long;
    logic [CW-1:0] o_frame_count;

    dac_spi_rx #(.DAC_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_sclk        (i_sclk),
        .i_mosi        (i_mosi),
        .i_cs_n        (i_cs_n),
        .i_ldac_n      (i_ldac_n),
        .o_input_reg   (o_input_reg),
        .o_dac_code    (o_dac_code),
        .o_word_valid  (o_word_valid),
        .o_update      (o_update),
        .o_err_short   (o_err_short),
        .o_err_long    (o_err_long),
        .o_frame_count (o_frame_count)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wvCount = 0, updCount = 0, shortCount = 0, longCount = 0;
    int lastWvCycle = -1, lastUpdCycle = -1, csHighCycle = 0;

    logic [W-1:0]  expInputReg = '0, expDac = '0;
    logic [CW-1:0] expCount = '0;
    logic          expWv = 1'b0, expUpd = 1'b0, expShort = 1'b0, expLong = 1'b0;

    bit           armed = 1'b0, inFrame = 1'b0;
    int           bitsSeen = 0;
    logic [W-1:0] frameData = '0;
    logic         prevCs = 1'b1, prevSclk = 1'b0, prevLdac = 1'b1;
    int           evDue[$];
    int           evKind[$];
    logic [W-1:0] evData[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level model: reads pins as sampled on each edge, classifies whole frames
    // by bit count, and schedules the resulting output events LAT+1 edges later.
    always @(posedge i_clk) begin : model
        int           kind;
        logic [W-1:0] d;
        bit           updNow;
        int           due;
        cyc = cyc + 1;
        expWv = 1'b0; expUpd = 1'b0; expShort = 1'b0; expLong = 1'b0;
        if (!i_rst_n) begin
            expInputReg = '0; expDac = '0; expCount = '0;
            armed = 1'b0; inFrame = 1'b0; bitsSeen = 0; frameData = '0;
            prevCs = 1'b1; prevSclk = 1'b0; prevLdac = 1'b1;
            evDue.delete(); evKind.delete(); evData.delete();
        end else begin
            updNow = 1'b0;
            while (evDue.size() > 0 && evDue[0] == cyc) begin
                void'(evDue.pop_front());
                kind = evKind.pop_front();
                d    = evData.pop_front();
                case (kind)
                    K_WORD:  begin expInputReg = d; expWv = 1'b1; expCount = expCount + 16'd1; end
                    K_SHORT: expShort = 1'b1;
                    K_LONG:  expLong = 1'b1;
                    default: updNow = 1'b1;
                endcase
            end
            if (updNow) begin
                expDac = expInputReg;
                expUpd = 1'b1;
            end
            due = cyc + LAT + 1;
            if (armed) begin
                if (inFrame && i_cs_n && !prevCs) begin
                    inFrame = 1'b0;
                    evDue.push_back(due);
                    evKind.push_back(bitsSeen < W ? K_SHORT : (bitsSeen > W ? K_LONG : K_WORD));
                    evData.push_back(frameData);
                end else if (!inFrame && !i_cs_n && prevCs) begin
                    inFrame = 1'b1; bitsSeen = 0; frameData = '0;
                end else if (inFrame && !i_cs_n && i_sclk && !prevSclk) begin
                    bitsSeen++;
                    if (bitsSeen <= W) frameData = {frameData[W-2:0], i_mosi};
                end
                if (!i_ldac_n && prevLdac) begin
                    evDue.push_back(due);
                    evKind.push_back(K_UPD);
                    evData.push_back('0);
                end
            end
            if (i_cs_n) armed = 1'b1;
            prevCs = i_cs_n; prevSclk = i_sclk; prevLdac = i_ldac_n;
        end
    end

    // Every-cycle comparison against the model, one time step after the edge.
    always @(posedge i_clk) begin
        #1;
        checkOutput("input_reg",   32'(o_input_reg),   32'(expInputReg));
        checkOutput("dac_code",    32'(o_dac_code),    32'(expDac));
        checkOutput("frame_count", 32'(o_frame_count), 32'(expCount));
        checkOutput("word_valid",  32'(o_word_valid),  32'(expWv));
        checkOutput("update",      32'(o_update),      32'(expUpd));
        checkOutput("err_short",   32'(o_err_short),   32'(expShort));
        checkOutput("err_long",    32'(o_err_long),    32'(expLong));
        if (o_word_valid === 1'b1) begin wvCount++; lastWvCycle = cyc; end
        if (o_update === 1'b1)     begin updCount++; lastUpdCycle = cyc; end
        if (o_err_short === 1'b1)  shortCount++;
        if (o_err_long === 1'b1)   longCount++;
    end

    task automatic sendBits(input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            @(negedge i_clk);
            i_mosi = data[i];
            repeat (3) @(negedge i_clk);
            i_sclk = 1'b1;
            repeat (4) @(negedge i_clk);
            i_sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input int nbits, input bit ldacWithCs);
        @(negedge i_clk);
        i_cs_n = 1'b0;
        repeat (4) @(negedge i_clk);
        sendBits(data, nbits);
        repeat (4) @(negedge i_clk);
        i_cs_n = 1'b1;
        if (ldacWithCs) i_ldac_n = 1'b0;
        @(posedge i_clk);
        #1 csHighCycle = cyc;
        @(negedge i_clk);
        i_ldac_n = 1'b1;
        repeat (10) @(negedge i_clk);
    endtask

    task automatic pulseLdac();
        @(negedge i_clk);
        i_ldac_n = 1'b0;
        @(negedge i_clk);
        i_ldac_n = 1'b1;
        repeat (10) @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wv0, upd0, sh0, lg0;
        $display("[TB] start, input latency L=%0d", LAT);

        repeat (3) @(negedge i_clk);
        checkOutput("reset_input_reg",   32'(o_input_reg),   32'h0);
        checkOutput("reset_frame_count", 32'(o_frame_count), 32'h0);
        checkOutput("reset_pulses", 32'({o_word_valid, o_update, o_err_short, o_err_long}), 32'h0);
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);

        $display("[TB] good frame 0xA5C3 then LDAC");
        wv0 = wvCount; upd0 = updCount;
        applyStimulus(32'hA5C3, 16, 1'b0);
        checkOutput("latency_cs_to_valid", 32'(lastWvCycle - csHighCycle), 32'(LAT + 1));
        pulseLdac();
        checkOutput("a5c3_valid_pulses",  32'(wvCount - wv0),   32'd1);
        checkOutput("a5c3_input_reg",     32'(o_input_reg),     32'hA5C3);
        checkOutput("a5c3_update_pulses", 32'(updCount - upd0), 32'd1);
        checkOutput("a5c3_dac_code",      32'(o_dac_code),      32'hA5C3);
        checkOutput("a5c3_frame_count",   32'(o_frame_count),   32'd1);

        $display("[TB] short frame of 12 bits");
        sh0 = shortCount; wv0 = wvCount;
        applyStimulus(32'hABC, 12, 1'b0);
        checkOutput("short_pulses",      32'(shortCount - sh0), 32'd1);
        checkOutput("short_no_valid",    32'(wvCount - wv0),    32'd0);
        checkOutput("short_input_reg",   32'(o_input_reg),      32'hA5C3);
        checkOutput("short_frame_count", 32'(o_frame_count),    32'd1);

        $display("[TB] long frame of 17 bits");
        lg0 = longCount; wv0 = wvCount;
        applyStimulus(32'h1ABCD, 17, 1'b0);
        checkOutput("long_pulses",      32'(longCount - lg0), 32'd1);
        checkOutput("long_no_valid",    32'(wvCount - wv0),   32'd0);
        checkOutput("long_input_reg",   32'(o_input_reg),     32'hA5C3);
        checkOutput("long_frame_count", 32'(o_frame_count),   32'd1);

        $display("[TB] frame 0x1234 with LDAC coincident with CS rise");
        wv0 = wvCount; upd0 = updCount;
        applyStimulus(32'h1234, 16, 1'b1);
        checkOutput("coinc_valid_pulses",  32'(wvCount - wv0),   32'd1);
        checkOutput("coinc_update_pulses", 32'(updCount - upd0), 32'd1);
        checkOutput("coinc_valid_cycle",   32'(lastWvCycle - csHighCycle),  32'(LAT + 1));
        checkOutput("coinc_update_cycle",  32'(lastUpdCycle - csHighCycle), 32'(LAT + 1));
        checkOutput("coinc_dac_code",      32'(o_dac_code),    32'h1234);
        checkOutput("coinc_input_reg",     32'(o_input_reg),   32'h1234);
        checkOutput("coinc_frame_count",   32'(o_frame_count), 32'd2);

        $display("[TB] reset in the middle of a frame");
        @(negedge i_clk);
        i_cs_n = 1'b0;
        repeat (4) @(negedge i_clk);
        sendBits(32'hC3, 8);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("midrst_input_reg",   32'(o_input_reg),   32'h0);
        checkOutput("midrst_dac_code",    32'(o_dac_code),    32'h0);
        checkOutput("midrst_frame_count", 32'(o_frame_count), 32'h0);
        i_rst_n = 1'b1;
        wv0 = wvCount; sh0 = shortCount; lg0 = longCount;
        repeat (4) @(negedge i_clk);
        sendBits(32'h5A, 8);
        repeat (4) @(negedge i_clk);
        i_cs_n = 1'b1;
        repeat (10) @(negedge i_clk);
        checkOutput("midrst_tail_ignored", 32'(wvCount - wv0 + shortCount - sh0 + longCount - lg0), 32'd0);
        applyStimulus(32'h00FF, 16, 1'b0);
        checkOutput("after_rst_valid_pulses", 32'(wvCount - wv0),   32'd1);
        checkOutput("after_rst_input_reg",    32'(o_input_reg),     32'h00FF);
        checkOutput("after_rst_frame_count",  32'(o_frame_count),   32'd1);
        checkOutput("after_rst_dac_code",     32'(o_dac_code),      32'h0);

        repeat (5) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_spi_rx.md
DAC_SPI_RX -- requirements
Module: dac_spi_rx

Interface
REQ-001 SHALL have parameter DAC_WIDTH, default 16, the frame length in bits and the width of the code registers.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the frame counter.
REQ-003 SHALL have port i_clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_sclk  input  1  SPI clock, mode 0 (idle low, MOSI sampled on rising edge).
REQ-006 SHALL have port i_mosi  input  1  serial data, MSB first.
REQ-007 SHALL have port i_cs_n  input  1  frame select, active-low.
REQ-008 SHALL have port i_ldac_n  input  1  load-DAC strobe, active-low.
REQ-009 SHALL have port o_input_reg  output  DAC_WIDTH  last complete received word.
REQ-010 SHALL have port o_dac_code  output  DAC_WIDTH  emulated DAC output code.
REQ-011 SHALL have port o_word_valid  output  1  one-cycle pulse when o_input_reg is loaded.
REQ-012 SHALL have port o_update  output  1  one-cycle pulse when o_dac_code is loaded.
REQ-013 SHALL have port o_err_short / o_err_long  output  1 each  one-cycle pulse on a frame with fewer / more than DAC_WIDTH bits.
REQ-014 SHALL have port o_frame_count  output  CNT_WIDTH  count of good frames, wraps to 0 after all-ones.

Function
REQ-015 SHALL pass i_sclk, i_mosi, i_cs_n and i_ldac_n through an input stage of L cycles (L per REQ-030/031) before any use; edges SHALL be detected by comparing the staged value with its value one cycle earlier.
REQ-016 SHALL implement states WAIT, IDLE, RECV, FULL.
REQ-017 WAIT: entered on reset; exits to IDLE after one cycle with staged cs_n high; SCLK and LDAC SHALL be ignored in WAIT.
REQ-018 IDLE -> RECV on a staged cs_n falling edge; bit counter SHALL clear and the shift register SHALL clear.
REQ-019 RECV: each staged sclk rising edge SHALL shift staged mosi into the LSB and increment the bit counter; at DAC_WIDTH bits -> FULL.
REQ-020 FULL: a further sclk rising edge SHALL mark the frame long; shift register SHALL hold.
REQ-021 On a staged cs_n rising edge in RECV, o_err_short SHALL pulse the next cycle; o_input_reg SHALL be unchanged; -> IDLE.
REQ-022 On a staged cs_n rising edge in FULL: if long, o_err_long SHALL pulse; otherwise o_input_reg <= shift register, o_word_valid pulses and o_frame_count increments, all on the next cycle; -> IDLE.
REQ-023 SCLK edges while staged cs_n is high SHALL be ignored.
REQ-024 A staged ldac_n falling edge in IDLE, RECV or FULL SHALL load o_dac_code from o_input_reg and pulse o_update on the next cycle.
REQ-025 If the ldac_n falling edge and a good cs_n rising edge are staged in the same cycle, o_dac_code SHALL take the newly received word. Both o_word_valid and o_update SHALL pulse in the same cycle.
REQ-026 Latency from the i_clk edge that first samples i_cs_n high to o_word_valid high SHALL be L+1 cycles.

Reset
REQ-027 While i_rst_n is low, all outputs SHALL be 0, state SHALL be WAIT, and the counters and shift register SHALL be 0.
REQ-028 Input-stage registers SHALL reset to idle levels: cs_n=1, ldac_n=1, sclk=0, mosi=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; if cs_n is still low at release, that frame SHALL be ignored per REQ-017.

Configuration
REQ-030 With DAC_SPI_RX_SYNC_EN defined, the input stage SHALL be a two-flop synchronizer (L=2), for inputs asynchronous to i_clk; the sclk high and low times SHALL each be at least 3 i_clk cycles.
REQ-031 Without DAC_SPI_RX_SYNC_EN, the input stage SHALL be a single register (L=1), for inputs generated from i_clk; the sclk high and low times SHALL each be at least 1 cycle.

Verification
REQ-032 Frame 0xA5C3, 16 bits, then ldac_n low for 1 cycle -> o_word_valid once, o_input_reg=0xA5C3, o_update once, o_dac_code=0xA5C3, o_frame_count=1.
REQ-033 Frame of 12 bits 0xABC -> o_err_short pulse; o_input_reg and o_frame_count unchanged.
REQ-034 Frame of 17 bits -> o_err_long pulse; o_input_reg unchanged.
REQ-035 Frame 0x1234 with ldac_n falling in the same staged cycle as the cs_n rise -> o_word_valid and o_update in the same cycle, o_dac_code=0x1234.
REQ-036 Assert i_rst_n low after 8 bits, release with cs_n low, finish the frame, then send 0x00FF -> only 0x00FF accepted, o_frame_count=1.
REQ-037 Build with and without DAC_SPI_RX_SYNC_EN -> o_word_valid 3 and 2 cycles respectively after the cycle i_cs_n is first sampled high.
